// File: rtl/johnson_phase_decoder_pkg.sv
// Shared types and the Johnson code decode function for the phase decoder.
// Used by both the RTL and the bench model.
package jpd_pkg;

  localparam int JPD_MAX_W     = 32;
  localparam int JPD_IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef enum logic [2:0] {
    START   = 3'd0,
    ADVANCE = 3'd1,
    HOLD    = 3'd2,
    RESTART = 3'd3,
    ERROR   = 3'd4
  } step_class_e;

  typedef struct packed {
    logic                     valid;
    logic [JPD_IDX_MAX_W-1:0] idx;
  } jpd_code_t;

  // A legal code of popcount p is either the low thermometer of p ones or the high one.
  function automatic jpd_code_t jpd_idx(input logic [JPD_MAX_W-1:0] code, input int width);
    jpd_code_t              res;
    logic [JPD_MAX_W-1:0]   lsb_t;
    logic [JPD_MAX_W-1:0]   msb_t;
    int                     pop;
    pop   = 0;
    lsb_t = {JPD_MAX_W{1'b0}};
    msb_t = {JPD_MAX_W{1'b0}};
    for (int i = 0; i < JPD_MAX_W; i++) begin
      if ((i < width) && code[i]) begin
        pop++;
      end else begin
        pop = pop;
      end
    end
    for (int i = 0; i < JPD_MAX_W; i++) begin
      lsb_t[i] = (i < pop);
      msb_t[i] = (i >= (width - pop)) && (i < width);
    end
    res.valid = (code == lsb_t) || (code == msb_t);
    if (!res.valid) begin
      res.idx = {JPD_IDX_MAX_W{1'b0}};
    end else if (code[0] || (pop == 0)) begin
      res.idx = JPD_IDX_MAX_W'(pop);
    end else begin
      res.idx = JPD_IDX_MAX_W'((2 * width) - pop);
    end
    return res;
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Count bus from the Johnson counter and decoded phase outputs.
interface johnson_phase_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]   count;
  logic [2*WIDTH-1:0] phase_oh;
  logic [IDX_W-1:0]   phase_idx;
  logic               code_valid;
  logic               seq_err;
  logic               wrap;
  logic               locked;
  logic [ERR_W-1:0]   err_count;

  modport master (
    output count,
    input  phase_oh, phase_idx, code_valid, seq_err, wrap, locked, err_count
  );

  modport slave (
    input  count,
    output phase_oh, phase_idx, code_valid, seq_err, wrap, locked, err_count
  );
endinterface

// File: rtl/johnson_phase_decoder_code_check.sv
// Combinational map from a Johnson code to its phase index and legality flag.
module johnson_code_check
  import jpd_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  jpd_code_t dec_s;
  logic      unused_idx_s;

  // Decode through the shared package function; high index bits are always zero here.
  always_comb begin
    dec_s        = jpd_idx(JPD_MAX_W'(code), WIDTH);
    idx          = dec_s.idx[IDX_W-1:0];
    valid        = dec_s.valid;
    unused_idx_s = ^dec_s.idx[JPD_IDX_MAX_W-1:IDX_W];
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: registered decode, step classification and lock FSM.
// Define JPD_ERR_COUNT_EN to build the saturating error counter.
module johnson_phase_decoder
  import jpd_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  johnson_phase_decoder_if.slave  bus
);

  localparam int PH     = 2 * WIDTH;
  localparam int IDX_W  = $clog2(PH);
  localparam int PROG_W = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PH - 1);
  localparam logic [PROG_W-1:0] LOCK_TGT = PROG_W'(LOCK_CNT);

  logic [IDX_W-1:0]  cur_idx_s;
  logic              cur_valid_s;
  logic [IDX_W-1:0]  prev_idx_s;
  logic              prev_chk_valid_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [PROG_W-1:0] prog_inc_s;
  step_class_e       step_s;
  lock_state_e       state_s;
  logic [PROG_W-1:0] prog_s;

  logic [WIDTH-1:0]  prev_code_r;
  logic              prev_valid_r;
  lock_state_e       state_r;
  logic [PROG_W-1:0] prog_r;
  logic [PH-1:0]     phase_oh_r;
  logic [IDX_W-1:0]  phase_idx_r;
  logic              code_valid_r;
  logic              seq_err_r;
  logic              wrap_r;
  logic              locked_r;

  johnson_code_check #(.WIDTH(WIDTH)) u_cur_chk (
    .code  (bus.count),
    .idx   (cur_idx_s),
    .valid (cur_valid_s)
  );

  johnson_code_check #(.WIDTH(WIDTH)) u_prev_chk (
    .code  (prev_code_r),
    .idx   (prev_idx_s),
    .valid (prev_chk_valid_s)
  );

  assign next_idx_s = (prev_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : (prev_idx_s + IDX_W'(1'b1));
  assign prog_inc_s = prog_r + PROG_W'(1'b1);

  // Step classifier; a zero code after the last phase is a normal advance, not a restart.
  always_comb begin
    step_s = ERROR;
    if (!cur_valid_s) begin
      step_s = ERROR;
    end else if (!(prev_valid_r && prev_chk_valid_s)) begin
      step_s = START;
    end else if (bus.count == prev_code_r) begin
      step_s = HOLD;
    end else if (cur_idx_s == next_idx_s) begin
      step_s = ADVANCE;
    end else if ((bus.count == {WIDTH{1'b0}}) && (prev_idx_s != LAST_IDX) &&
                 (prev_idx_s != {IDX_W{1'b0}})) begin
      step_s = RESTART;
    end else begin
      step_s = ERROR;
    end
  end

  // Lock FSM next state and lock progress.
  always_comb begin
    state_s = state_r;
    prog_s  = prog_r;
    case (state_r)
      UNLOCKED: begin
        if (cur_valid_s) begin
          state_s = LOCKING;
          prog_s  = {PROG_W{1'b0}};
        end else begin
          state_s = UNLOCKED;
        end
      end
      LOCKING: begin
        case (step_s)
          ADVANCE: begin
            prog_s = prog_inc_s;
            if (prog_inc_s == LOCK_TGT) begin
              state_s = LOCKED;
            end else begin
              state_s = LOCKING;
            end
          end
          RESTART: prog_s = {PROG_W{1'b0}};
          ERROR: begin
            state_s = UNLOCKED;
            prog_s  = {PROG_W{1'b0}};
          end
          default: state_s = LOCKING;
        endcase
      end
      LOCKED: begin
        case (step_s)
          RESTART: begin
            state_s = LOCKING;
            prog_s  = {PROG_W{1'b0}};
          end
          ERROR: begin
            state_s = UNLOCKED;
            prog_s  = {PROG_W{1'b0}};
          end
          default: state_s = LOCKED;
        endcase
      end
      default: begin
        state_s = UNLOCKED;
        prog_s  = {PROG_W{1'b0}};
      end
    endcase
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code_r  <= {WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
      state_r      <= UNLOCKED;
      prog_r       <= {PROG_W{1'b0}};
      phase_oh_r   <= {PH{1'b0}};
      phase_idx_r  <= {IDX_W{1'b0}};
      code_valid_r <= 1'b0;
      seq_err_r    <= 1'b0;
      wrap_r       <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      prev_code_r  <= bus.count;
      prev_valid_r <= cur_valid_s;
      state_r      <= state_s;
      prog_r       <= prog_s;
      phase_oh_r   <= cur_valid_s ? ({{(PH-1){1'b0}}, 1'b1} << cur_idx_s) : {PH{1'b0}};
      phase_idx_r  <= cur_valid_s ? cur_idx_s : {IDX_W{1'b0}};
      code_valid_r <= cur_valid_s;
      seq_err_r    <= (step_s == ERROR);
      wrap_r       <= (step_s == ADVANCE) && (prev_idx_s == LAST_IDX);
      locked_r     <= (state_s == LOCKED);
    end
  end

`ifdef JPD_ERR_COUNT_EN
  logic [ERR_W-1:0] err_cnt_r;

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {ERR_W{1'b0}};
    end else if ((step_s == ERROR) && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_W'(1'b1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_count = err_cnt_r;
`else
  assign bus.err_count = {ERR_W{1'b0}};
`endif

  assign bus.phase_oh   = phase_oh_r;
  assign bus.phase_idx  = phase_idx_r;
  assign bus.code_valid = code_valid_r;
  assign bus.seq_err    = seq_err_r;
  assign bus.wrap       = wrap_r;
  assign bus.locked     = locked_r;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder (WIDTH=4); honours JPD_ERR_COUNT_EN.
module tb_johnson_phase_decoder;
  import jpd_pkg::*;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int PH       = 2 * WIDTH;

  typedef struct {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       cv;
    logic       err;
    logic       wrap;
    logic       lk;
    logic [7:0] ec;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] seq [8];
  logic [3:0] m_prev;
  logic       m_pvalid;
  int         m_state;
  int         m_prog;
  int         m_err;
  int         ph;

  always #5 clk = ~clk;

  johnson_phase_decoder_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  johnson_phase_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev   = 4'h0;
    m_pvalid = 1'b0;
    m_state  = 0;
    m_prog   = 0;
    m_err    = 0;
    sb_q.delete();
  endtask

  // Reference: state 0=UNLOCKED, 1=LOCKING, 2=LOCKED
  task automatic model_step(input logic [3:0] c);
    jpd_code_t cur;
    jpd_code_t prv;
    exp_t      e;
    logic      adv;
    logic      rst_step;
    logic      err;
    cur      = jpd_idx(32'(c), WIDTH);
    prv      = jpd_idx(32'(m_prev), WIDTH);
    adv      = 1'b0;
    rst_step = 1'b0;
    err      = 1'b0;
    if (!cur.valid) err = 1'b1;
    else if (m_pvalid) begin
      if (c == m_prev) err = 1'b0;
      else if (int'(cur.idx) == (int'(prv.idx) + 1) % PH) adv = 1'b1;
      else if (c == 4'h0 && int'(prv.idx) != PH - 1 && prv.idx != 8'd0) rst_step = 1'b1;
      else err = 1'b1;
    end
    if (m_state == 0) begin
      if (cur.valid) begin m_state = 1; m_prog = 0; end
    end else if (err) begin
      m_state = 0; m_prog = 0;
    end else if (rst_step) begin
      m_state = 1; m_prog = 0;
    end else if (adv && m_state == 1) begin
      m_prog++;
      if (m_prog == LOCK_CNT) m_state = 2;
    end
    if (err && m_err < 255) m_err++;
    e.cv   = cur.valid;
    e.idx  = cur.valid ? cur.idx[2:0] : 3'd0;
    e.oh   = cur.valid ? (8'd1 << cur.idx) : 8'd0;
    e.err  = err;
    e.wrap = adv && (int'(prv.idx) == PH - 1);
    e.lk   = (m_state == 2);
`ifdef JPD_ERR_COUNT_EN
    e.ec   = 8'(m_err);
`else
    e.ec   = 8'd0;
`endif
    m_prev   = c;
    m_pvalid = cur.valid;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    bus.count = c;
    model_step(c);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("phase_oh",   32'(bus.phase_oh),  32'(e.oh));
    check_eq("phase_idx",  32'(bus.phase_idx), 32'(e.idx));
    check_eq("code_valid", 32'(bus.code_valid), 32'(e.cv));
    check_eq("seq_err",    32'(bus.seq_err),   32'(e.err));
    check_eq("wrap",       32'(bus.wrap),      32'(e.wrap));
    check_eq("locked",     32'(bus.locked),    32'(e.lk));
    check_eq("err_count",  32'(bus.err_count), 32'(e.ec));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      ph = (ph + 1) % PH;
      drive(seq[ph]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_oh"},   32'(bus.phase_oh),   32'd0);
    check_eq({tag, "_idx"},  32'(bus.phase_idx),  32'd0);
    check_eq({tag, "_cv"},   32'(bus.code_valid), 32'd0);
    check_eq({tag, "_err"},  32'(bus.seq_err),    32'd0);
    check_eq({tag, "_wrap"}, 32'(bus.wrap),       32'd0);
    check_eq({tag, "_lk"},   32'(bus.locked),     32'd0);
    check_eq({tag, "_ec"},   32'(bus.err_count),  32'd0);
  endtask

  initial begin
    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    bus.count = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: free-running count from 0001, two full wraps
    ph = 1;
    drive(seq[1]);
    run(16);
    check_eq("t1_locked", 32'(bus.locked), 32'd1);

    // 2: illegal code while locked, then restart from a legal code
    drive(4'h5);
    check_eq("t2_seq_err", 32'(bus.seq_err), 32'd1);
    check_eq("t2_locked", 32'(bus.locked), 32'd0);
    drive(seq[ph]);
    run(6);

    // 3: skipped phase 0011 -> 1110
    while (ph != 2) run(1);
    ph = 5;
    drive(seq[5]);
    check_eq("t3_seq_err", 32'(bus.seq_err), 32'd1);
    run(6);
    check_eq("t3_relock", 32'(bus.locked), 32'd1);

    // 4: upstream reset at phase 5
    while (ph != 5) run(1);
    ph = 0;
    drive(seq[0]);
    check_eq("t4_no_err", 32'(bus.seq_err), 32'd0);
    check_eq("t4_unlock", 32'(bus.locked), 32'd0);
    run(4);
    check_eq("t4_relock", 32'(bus.locked), 32'd1);

    // 5: hold at 0111 while locking with progress 2
    drive(4'h5);
    ph = 1;
    drive(seq[1]);
    run(2);
    drive(seq[3]);
    drive(seq[3]);
    check_eq("t5_hold_err", 32'(bus.seq_err), 32'd0);
    run(2);
    check_eq("t5_locked", 32'(bus.locked), 32'd1);

    // 6: asynchronous reset mid-run, then saturate the error counter
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (300) drive(4'h5);
`ifdef JPD_ERR_COUNT_EN
    check_eq("t6_sat", 32'(bus.err_count), 32'd255);
`else
    check_eq("t6_sat", 32'(bus.err_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
